// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: chase, bounce, blink or static patterns stepped by a
// programmable clock divider, configured through a valid/ready register port.
module led_seq_ctrl #(
    parameter int NUM_LEDS    = 7,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 12_500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_addr,
    input  logic [DIV_W-1:0]    cfg_wdata,
    output logic                step_pulse,
    output logic [NUM_LEDS-1:0] led
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0]    POS_MAX = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_APPLY} state_t;
    typedef enum logic [1:0] {M_STATIC, M_CHASE, M_BOUNCE, M_BLINK} mode_t;

    state_t              state_q, state_d;
    logic                ready_q;
    mode_t               mode_q;
    logic [DIV_W-1:0]    div_q, cnt_q;
    logic [NUM_LEDS-1:0] pat_q, led_q;
    logic [POS_W-1:0]    pos_q, pos_nxt;
    logic                dir_down_q, dir_nxt;
    logic [1:0]          pend_addr_q;
    logic                pend_restart_q;

    logic                accept;
    logic                terminal;
    logic [NUM_LEDS-1:0] led_step;
    logic [NUM_LEDS-1:0] led_first;
    logic                restart;
    logic                unused_wdata;

    assign terminal     = (cnt_q >= div_q - DIV_W'(1));
    assign restart      = (pend_addr_q == 2'd0) || (pend_addr_q == 2'd3 && pend_restart_q);
    assign led          = led_q;
    assign unused_wdata = ^cfg_wdata;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b0;
        accept     = 1'b0;
        step_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready = ready_q;
                accept    = cfg_valid & ready_q;
                if (accept)      state_d = S_APPLY;
                else if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                cfg_ready = ready_q;
                accept    = cfg_valid & ready_q;
                if (accept)       state_d = S_APPLY;
                else if (!enable) state_d = S_IDLE;
                else              step_pulse = terminal;
            end
            S_APPLY: state_d = enable ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next pattern position/LED value for the current mode, used on a step.
    always_comb begin
        pos_nxt  = pos_q;
        dir_nxt  = dir_down_q;
        led_step = led_q;
        case (mode_q)
            M_CHASE: begin
                pos_nxt  = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
                led_step = LED_ONE << pos_nxt;
            end
            M_BOUNCE: begin
                if (!dir_down_q) begin
                    pos_nxt = pos_q + POS_W'(1);
                    if (pos_nxt == POS_MAX) dir_nxt = 1'b1;
                end else begin
                    pos_nxt = pos_q - POS_W'(1);
                    if (pos_nxt == '0) dir_nxt = 1'b0;
                end
                led_step = LED_ONE << pos_nxt;
            end
            M_BLINK: led_step = (led_q == '0) ? '1 : '0;
            default: ;
        endcase
    end

    always_comb begin
        case (mode_q)
            M_STATIC: led_first = pat_q;
            M_BLINK:  led_first = '1;
            default:  led_first = LED_ONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    // A write edge suppresses any step; its effect on divider/pattern lands
    // at the end of the following APPLY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q         <= M_CHASE;
            div_q          <= DIV_W'(DEFAULT_DIV);
            pat_q          <= LED_ONE;
            cnt_q          <= '0;
            pos_q          <= '0;
            dir_down_q     <= 1'b0;
            led_q          <= LED_ONE;
            pend_addr_q    <= 2'd0;
            pend_restart_q <= 1'b0;
        end else if (accept) begin
            pend_addr_q    <= cfg_addr;
            pend_restart_q <= cfg_wdata[0];
            case (cfg_addr)
                2'd0:    mode_q <= mode_t'(cfg_wdata[1:0]);
                2'd1:    div_q  <= (cfg_wdata == '0) ? DIV_W'(1) : cfg_wdata;
                2'd2:    pat_q  <= cfg_wdata[NUM_LEDS-1:0];
                default: ;
            endcase
        end else if (state_q == S_APPLY) begin
            if (restart) begin
                cnt_q      <= '0;
                pos_q      <= '0;
                dir_down_q <= 1'b0;
                led_q      <= led_first;
            end else if (pend_addr_q == 2'd1) begin
                cnt_q <= '0;
            end else if (pend_addr_q == 2'd2 && mode_q == M_STATIC) begin
                led_q <= pat_q;
            end
        end else if (state_q == S_RUN && enable) begin
            if (step_pulse) begin
                cnt_q      <= '0;
                pos_q      <= pos_nxt;
                dir_down_q <= dir_nxt;
                led_q      <= led_step;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a step-index reference model.
module tb_led_seq_ctrl;

    localparam int N    = 7;
    localparam int DW   = 24;
    localparam int DDIV = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_ready;
    logic          step_pulse;
    logic [N-1:0]  led;

    int n_checks = 0;
    int n_fail   = 0;

    led_seq_ctrl #(.NUM_LEDS(N), .DIV_W(DW), .DEFAULT_DIV(DDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .step_pulse (step_pulse),
        .led        (led)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: the pattern is a function of the step index k since the
    // last restart, not of any position/direction register.
    int           m_mode, m_div, m_cnt, m_k, p_addr;
    logic [N-1:0] m_pat, m_led;
    logic [DW-1:0] p_data;
    bit           m_ready, m_apply, m_run;

    function automatic logic [N-1:0] pattern(input int mode, input int k, input logic [N-1:0] pat);
        int p;
        case (mode)
            0: return pat;
            1: return N'(1) << (k % N);
            2: begin
                p = k % (2 * N - 2);
                if (p >= N) p = 2 * N - 2 - p;
                return N'(1) << p;
            end
            default: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
        endcase
    endfunction

    function automatic bit m_accept();
        return cfg_valid && m_ready && !m_apply;
    endfunction

    function automatic bit m_pulse();
        return m_run && !m_apply && enable && !m_accept() && (m_cnt == m_div - 1);
    endfunction

    task automatic model_reset();
        m_mode = 1; m_div = DDIV; m_pat = N'(1); m_cnt = 0; m_k = 0;
        m_led = N'(1); m_ready = 0; m_apply = 0; m_run = 0;
        p_addr = 0; p_data = '0;
    endtask

    task automatic model_step();
        if (m_apply) begin
            if (p_addr == 0 || (p_addr == 3 && p_data[0])) begin
                m_cnt = 0; m_k = 0; m_led = pattern(m_mode, 0, m_pat);
            end else if (p_addr == 1) begin
                m_cnt = 0;
            end else if (p_addr == 2 && m_mode == 0) begin
                m_led = m_pat;
            end
            m_apply = 0;
            m_run   = enable;
        end else if (m_accept()) begin
            case (cfg_addr)
                2'd0: m_mode = int'(cfg_wdata[1:0]);
                2'd1: m_div  = (cfg_wdata == '0) ? 1 : int'(cfg_wdata);
                2'd2: m_pat  = cfg_wdata[N-1:0];
                default: ;
            endcase
            p_addr  = int'(cfg_addr);
            p_data  = cfg_wdata;
            m_apply = 1;
        end else if (m_run && enable) begin
            if (m_cnt == m_div - 1) begin
                m_cnt = 0;
                m_k++;
                if (m_mode != 0) m_led = pattern(m_mode, m_k, m_pat);
            end else begin
                m_cnt++;
            end
        end else begin
            m_run = enable;
        end
        m_ready = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, 2 time units after negedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("cmp_led", 32'(led), 32'(m_led));
            check("cmp_cfg_ready", 32'(cfg_ready), 32'(m_ready && !m_apply));
            check("cmp_step_pulse", 32'(step_pulse), 32'(m_pulse()));
        end
    end

    // Main-thread activity happens at negedge+3.
    task automatic nxt();
        @(negedge clk);
        #3;
    endtask

    task automatic write(input int addr, input int data);
        cfg_valid = 1'b1;
        cfg_addr  = 2'(addr);
        cfg_wdata = DW'(data);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cfg_ready) begin
                nxt();
                cfg_valid = 1'b0;
                return;
            end
            nxt();
        end
        check("write_timeout", 32'd1, 32'd0);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = 0;
        forever begin
            #1;
            if (step_pulse) return;
            if (n >= max) begin
                check("pulse_timeout", 32'(n), 32'(max + 1));
                return;
            end
            nxt();
            n++;
        end
    endtask

    logic [N-1:0] chase_exp  [8]  = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01, 7'h02};
    logic [N-1:0] bounce_exp [13] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h20,
                                      7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02};

    initial begin
        int n;
        logic [N-1:0] frozen;

        repeat (3) nxt();
        check("reset_led", 32'(led), 32'h01);
        check("reset_ready", 32'(cfg_ready), 32'd0);
        check("reset_pulse", 32'(step_pulse), 32'd0);
        rst = 1'b0;
        #1 check("ready_before_first_edge", 32'(cfg_ready), 32'd0);
        nxt();
        check("ready_after_first_edge", 32'(cfg_ready), 32'd1);

        // From reset: one IDLE cycle, then DEFAULT_DIV RUN cycles to the step.
        enable = 1'b1;
        wait_pulse(50, n);
        check("reset_latency", 32'(n), 32'd5);
        nxt();
        check("reset_first_step_led", 32'(led), 32'h02);

        // Chase, DIV=3.
        enable = 1'b0;
        write(1, 3);
        write(0, 1);
        nxt();
        check("chase_start_led", 32'(led), 32'h01);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_pulse(20, n);
            check("chase_gap", 32'(n), (i == 0) ? 32'd3 : 32'd2);
            nxt();
            check("chase_led", 32'(led), 32'(chase_exp[i]));
        end

        // Bounce, DIV=2.
        write(1, 2);
        write(0, 2);
        nxt();
        check("bounce_start_led", 32'(led), 32'h01);
        for (int i = 0; i < 13; i++) begin
            wait_pulse(20, n);
            check("bounce_gap", 32'(n), 32'd1);
            nxt();
            check("bounce_led", 32'(led), 32'(bounce_exp[i]));
        end

        // DIV=0 is stored as 1: a step on every RUN clock.
        write(1, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            wait_pulse(5, n);
            check("div0_gap", 32'(n), 32'd0);
            nxt();
        end

        // Blink MODE write on the terminal-count cycle: the write wins.
        write(1, 3);
        nxt();
        wait_pulse(20, n);
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_wdata = DW'(3);
        #1;
        check("coincide_pulse", 32'(step_pulse), 32'd0);
        check("coincide_ready", 32'(cfg_ready), 32'd1);
        nxt();
        cfg_valid = 1'b0;
        check("apply_ready", 32'(cfg_ready), 32'd0);
        nxt();
        check("blink_first_led", 32'(led), 32'h7f);
        check("blink_ready_back", 32'(cfg_ready), 32'd1);
        wait_pulse(20, n);
        check("blink_gap", 32'(n), 32'd2);
        nxt();
        check("blink_second_led", 32'(led), 32'h00);

        // Freeze for 10 cycles with the divider at 2 of DIV=8.
        write(1, 8);
        write(0, 1);
        nxt();
        nxt();
        nxt();
        enable = 1'b0;
        frozen = led;
        for (int i = 0; i < 10; i++) begin
            nxt();
            check("freeze_led", 32'(led), 32'(frozen));
            check("freeze_pulse", 32'(step_pulse), 32'd0);
        end
        enable = 1'b1;
        wait_pulse(40, n);
        check("resume_remaining", 32'(n), 32'd6);

        // Reset during APPLY of a MODE write aborts it.
        nxt();
        write(0, 3);
        rst = 1'b1;
        #1;
        check("rst_apply_led", 32'(led), 32'h01);
        check("rst_apply_ready", 32'(cfg_ready), 32'd0);
        nxt();
        nxt();
        check("rst_held_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        #1 check("rst_release_ready", 32'(cfg_ready), 32'd0);
        nxt();
        check("rst_edge_ready", 32'(cfg_ready), 32'd1);
        wait_pulse(40, n);
        check("rst_chase_latency", 32'(n), 32'd4);
        nxt();
        check("rst_chase_led", 32'(led), 32'h02);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                nxt();
                rst = 1'b0;
            end
            enable    = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            case (cfg_addr)
                2'd0:    cfg_wdata = DW'($urandom_range(0, 3));
                2'd1:    cfg_wdata = DW'($urandom_range(0, 4));
                2'd2:    cfg_wdata = DW'($urandom_range(0, 127));
                default: cfg_wdata = DW'($urandom_range(0, 3));
            endcase
        end
        cfg_valid = 1'b0;
        nxt();
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
